dma_cmd_dispatcher: RTL

Parametrised successor to the single-instruction processor/DMA control block. It buffers command words in a FIFO and decodes each as either a processor instruction or a DMA transfer. For a transfer it arbitrates the bus with the processor over a HOLD/HLDA handshake, with a timeout. It then launches the addressed DMA channel and releases the bus once that channel reports done.

---
 rtl/dma_cmd_dispatcher.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/dma_cmd_dispatcher.sv
// ---------------------------------------------------------------------------
// dma_cmd_dispatcher
//
// Buffers command words in a small FIFO and dispatches them one at a time.
// A command is either a processor instruction (forwarded as a one-cycle
// pulse) or a DMA transfer.  For a transfer the block requests the bus from
// the processor with HOLD/HLDA, launches the addressed channel once granted,
// waits for that channel's done pulse and then releases the bus.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   cmd_valid/ready     command push handshake; ready means FIFO not full
//   cmd_data            {mode, chan, src, dst, len}, MSB first
//   hold / hlda         bus request to / grant from the processor
//   proc_instr_valid    one-cycle pulse, proc_instr holds the stripped word
//   ch_start            one-hot channel start pulse
//   ch_src/dst/len      transfer descriptor shared by all channels
//   ch_done             per-channel completion pulse
//   busy                FSM active or FIFO not empty
//   err                 one-cycle pulse on a rejected command or HOLD timeout
//   xfer_count          completed DMA transfers (wrapping)
// ---------------------------------------------------------------------------
module dma_cmd_dispatcher #(
    parameter int AW           = 8,
    parameter int LW           = 8,
    parameter int NCH          = 2,
    parameter int DEPTH        = 4,
    parameter int HOLD_TIMEOUT = 64,
    localparam int CHW         = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int CW          = 1 + CHW + 2 * AW + LW
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [CW-1:0]   cmd_data,
    output logic            hold,
    input  logic            hlda,
    output logic            proc_instr_valid,
    output logic [CW-2:0]   proc_instr,
    output logic [NCH-1:0]  ch_start,
    output logic [AW-1:0]   ch_src,
    output logic [AW-1:0]   ch_dst,
    output logic [LW-1:0]   ch_len,
    input  logic [NCH-1:0]  ch_done,
    output logic            busy,
    output logic            err,
    output logic [15:0]     xfer_count
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int TW   = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_START = 3'd2,
        S_XFER  = 3'd3,
        S_REL   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [CW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;

    // FSM and registered outputs
    state_t          state_q;
    logic [TW-1:0]   timer_q;
    logic [CHW-1:0]  chan_q;
    logic            hold_q;
    logic            proc_instr_valid_q;
    logic [CW-2:0]   proc_instr_q;
    logic [NCH-1:0]  ch_start_q;
    logic [AW-1:0]   ch_src_q;
    logic [AW-1:0]   ch_dst_q;
    logic [LW-1:0]   ch_len_q;
    logic            err_q;
    logic [15:0]     xfer_count_q;

    // Head-of-FIFO decode
    logic            push_s;
    logic            pop_s;
    logic [CW-1:0]   head_s;
    logic            head_mode_s;
    logic [CHW-1:0]  head_chan_s;
    logic [AW-1:0]   head_src_s;
    logic [AW-1:0]   head_dst_s;
    logic [LW-1:0]   head_len_s;

    // Push/pop qualification and FIFO count next state
    always_comb begin
        push_s  = cmd_valid && (count_q != CNTW'(DEPTH));
        // Only IDLE consumes commands, so at most one pop per cycle.
        pop_s   = (state_q == S_IDLE) && (count_q != CNTW'(0));
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    // Field extraction from the word at the FIFO head
    always_comb begin
        head_s      = mem_q[rd_ptr_q];
        head_mode_s = head_s[CW-1];
        head_chan_s = head_s[CW-2 -: CHW];
        head_src_s  = head_s[2*AW+LW-1 -: AW];
        head_dst_s  = head_s[AW+LW-1 -: AW];
        head_len_s  = head_s[LW-1:0];
    end

    // FIFO storage write; contents are don't-care until pushed
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= cmd_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // Dispatch FSM with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q            <= S_IDLE;
            timer_q            <= '0;
            chan_q             <= '0;
            hold_q             <= 1'b0;
            proc_instr_valid_q <= 1'b0;
            proc_instr_q       <= '0;
            ch_start_q         <= '0;
            ch_src_q           <= '0;
            ch_dst_q           <= '0;
            ch_len_q           <= '0;
            err_q              <= 1'b0;
            xfer_count_q       <= '0;
        end else begin
            // Pulse outputs default low each cycle
            proc_instr_valid_q <= 1'b0;
            err_q              <= 1'b0;
            ch_start_q         <= '0;
            case (state_q)
                S_IDLE: begin
                    if (pop_s) begin
                        if (!head_mode_s) begin
                            proc_instr_q       <= head_s[CW-2:0];
                            proc_instr_valid_q <= 1'b1;
                        end else if ((head_len_s == LW'(0)) || (int'(head_chan_s) >= NCH)) begin
                            err_q <= 1'b1;
                        end else begin
                            chan_q   <= head_chan_s;
                            ch_src_q <= head_src_s;
                            ch_dst_q <= head_dst_s;
                            ch_len_q <= head_len_s;
                            hold_q   <= 1'b1;
                            timer_q  <= '0;
                            state_q  <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (hlda) begin
                        state_q <= S_START;
                    end else if (timer_q == TW'(HOLD_TIMEOUT - 1)) begin
                        // This is the HOLD_TIMEOUT-th cycle without a grant
                        hold_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_START: begin
                    ch_start_q <= NCH'(1) << chan_q;
                    state_q    <= S_XFER;
                end
                S_XFER: begin
                    // A done coincident with the start pulse is not ours yet
                    if ((ch_start_q == '0) && ch_done[chan_q]) begin
                        xfer_count_q <= xfer_count_q + 16'd1;
                        hold_q       <= 1'b0;
                        state_q      <= S_REL;
                    end
                end
                S_REL: begin
                    if (!hlda) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    hold_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready        = (count_q != CNTW'(DEPTH));
    assign busy             = (state_q != S_IDLE) || (count_q != CNTW'(0));
    assign hold             = hold_q;
    assign proc_instr_valid = proc_instr_valid_q;
    assign proc_instr       = proc_instr_q;
    assign ch_start         = ch_start_q;
    assign ch_src           = ch_src_q;
    assign ch_dst           = ch_dst_q;
    assign ch_len           = ch_len_q;
    assign err              = err_q;
    assign xfer_count       = xfer_count_q;

endmodule
